vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Pixel-rate raster timing generator for the VGA display path. It counts horizontal and vertical positions under a pixel clock-enable and decodes them into registered sync, display-enable and coordinate outputs. The display-enable output drives the RGB gating stage directly downstream. The coordinates and frame/line ticks feed the snake renderer, so that the renderer's RGB arrives aligned with `active`.

## Interface
Parameters (defaults give 640x480@60, 25 MHz pixel rate):
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync asserted level (0 = active-low)
- V_POL, 0, vsync asserted level
- CNT_W, 10, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_ce  in  1  pixel clock enable, one clk wide (e.g. every 4th clk at 100 MHz)
- hsync  out  1  horizontal sync at H_POL when asserted
- vsync  out  1  vertical sync at V_POL when asserted
- active  out  1  display enable; high inside the visible region
- x  out  CNT_W  horizontal position of the current pixel (raw counter, 0..H_TOTAL-1)
- y  out  CNT_W  vertical position of the current pixel (raw counter, 0..V_TOTAL-1)
- line_start  out  1  one-clk pulse when a pixel with x==0 is presented
- frame_start  out  1  one-clk pulse when pixel (0,0) is presented

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Internal counters h_cnt and v_cnt. Both change only on clk edges with pix_ce=1.
- Horizontal counter: h_cnt increments by 1. At H_TOTAL-1 it wraps to 0.
- Vertical counter: v_cnt increments only when h_cnt wraps. At V_TOTAL-1 with h_cnt at H_TOTAL-1, both wrap to 0.
- Output stage: on the same pix_ce edge, the output registers load the decode of the pre-increment (h_cnt, v_cnt). Outputs then hold until the next pix_ce.
- Decode rules:
  - x = h_cnt; y = v_cnt.
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hsync = H_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; otherwise ~H_POL.
  - vsync = V_POL when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC; otherwise ~V_POL. vsync changes only at line boundaries.
- Ticks: line_start and frame_start are registered on every clk. Each is high for exactly one clk: the clk in which the pix_ce edge loaded h_cnt==0 (line_start), or h_cnt==0 && v_cnt==0 (frame_start). A frame_start clk is always also a line_start clk.
- pix_ce held low: counters and outputs freeze; ticks drop to 0 after at most one clk.
- Reset (async assert, any time including mid-frame):
  - h_cnt = v_cnt = 0; x = y = 0; active = 0.
  - hsync = ~H_POL; vsync = ~V_POL.
  - line_start = frame_start = 0.
- After reset release, the first pix_ce edge presents pixel (0,0) and pulses both ticks.

## Timing
- Latency: outputs reflect the counter value held before each pix_ce edge. Outputs are valid from the clk after that edge for one full pixel period.
- All outputs come from flops; there are no combinational paths from inputs to outputs.
- Downstream renderer requirement: it samples x/y/frame_start and must produce RGB combinationally, or re-align its pipeline delay with active.
- Intervals with pix_ce continuous: line_start period = H_TOTAL pix_ce; frame_start period = H_TOTAL*V_TOTAL pix_ce (420000).
- The sync-window comparisons use full CNT_W arithmetic; the parameter sums must not overflow CNT_W.

## Test plan
- Reset, then pix_ce tied high:
  - first clk after release gives x=0, y=0, active=1, frame_start=1, line_start=1, hsync=1, vsync=1.
  - a second frame_start appears exactly 420000 clks later.
- Horizontal decode, pix_ce tied high:
  - active falls when x goes 639->640.
  - hsync is 0 for x=656..751 (96 pixels) and 1 at x=655 and x=752.
  - x wraps from 799 to 0 with line_start=1.
- Vertical decode:
  - active=0 for all x when y=480..524.
  - vsync is 0 exactly for y=490..491.
  - y wraps 524->0 on the same pixel as x 799->0, with frame_start=1.
- pix_ce every 4th clk:
  - each x value is held for 4 clks.
  - line_start is high for exactly 1 clk, never 4.
  - line period = 3200 clks.
- Freeze: drop pix_ce for 50 clks at x=300.
  - outputs hold x=300 throughout.
  - on resume, the next value is x=301.
- Reset mid-frame: assert rst_n=0 at x=700, y=200 (during hsync).
  - outputs immediately go to x=0, y=0, active=0, hsync=1, vsync=1.
  - after release, the first pix_ce yields frame_start=1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-enabled h/v counters decoded into registered
// sync, display-enable, coordinate and line/frame tick outputs.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_ce,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] ZERO_C   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SLO_C  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SHI_C  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST_C = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SLO_C  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SHI_C  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_TOTAL - 1);
  localparam logic             H_ASSERT_C = (H_POL != 0) ? 1'b1 : 1'b0;
  localparam logic             V_ASSERT_C = (V_POL != 0) ? 1'b1 : 1'b0;

  logic [CNT_W-1:0] h_cnt_r, v_cnt_r, x_r, y_r;
  logic [CNT_W-1:0] h_nxt_s, v_nxt_s;
  logic             hsync_r, vsync_r, active_r, line_start_r, frame_start_r;
  logic             hsync_s, vsync_s, active_s, h_zero_s, v_zero_s;

  // Next counter values: h wraps at end of line, v advances only on that wrap
  always_comb begin
    h_nxt_s = h_cnt_r;
    v_nxt_s = v_cnt_r;
    if (h_cnt_r == H_LAST_C) begin
      h_nxt_s = ZERO_C;
      if (v_cnt_r == V_LAST_C) begin
        v_nxt_s = ZERO_C;
      end else begin
        v_nxt_s = v_cnt_r + ONE_C;
      end
    end else begin
      h_nxt_s = h_cnt_r + ONE_C;
      v_nxt_s = v_cnt_r;
    end
  end

  // Decode of the current (pre-increment) position
  always_comb begin
    active_s = (h_cnt_r < H_ACT_C) && (v_cnt_r < V_ACT_C);
    hsync_s  = ((h_cnt_r >= H_SLO_C) && (h_cnt_r < H_SHI_C)) ? H_ASSERT_C : ~H_ASSERT_C;
    vsync_s  = ((v_cnt_r >= V_SLO_C) && (v_cnt_r < V_SHI_C)) ? V_ASSERT_C : ~V_ASSERT_C;
    h_zero_s = (h_cnt_r == ZERO_C);
    v_zero_s = (v_cnt_r == ZERO_C);
  end

  // Counters and output registers; ticks last exactly one clk after a pix_ce edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_r       <= ZERO_C;
      v_cnt_r       <= ZERO_C;
      x_r           <= ZERO_C;
      y_r           <= ZERO_C;
      active_r      <= 1'b0;
      hsync_r       <= ~H_ASSERT_C;
      vsync_r       <= ~V_ASSERT_C;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else if (pix_ce) begin
      h_cnt_r       <= h_nxt_s;
      v_cnt_r       <= v_nxt_s;
      x_r           <= h_cnt_r;
      y_r           <= v_cnt_r;
      active_r      <= active_s;
      hsync_r       <= hsync_s;
      vsync_r       <= vsync_s;
      line_start_r  <= h_zero_s;
      frame_start_r <= h_zero_s && v_zero_s;
    end else begin
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end
  end

  assign x           = x_r;
  assign y           = y_r;
  assign active      = active_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign line_start  = line_start_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a small-raster
// instance, checked every clk against a pixel-index model plus directed literals.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic pix_ce;

  logic       f_hs, f_vs, f_act, f_ls, f_fs;
  logic [9:0] f_x, f_y;
  logic       s_hs, s_vs, s_act, s_ls, s_fs;
  logic [4:0] s_x, s_y;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  longint n_ce = 0;
  bit     last_ce = 1'b0;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic act, hs, vs, ls, fs;
  } px_t;

  always #5 clk = ~clk;

  vga_timing_gen dut_full (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
    .hsync(f_hs), .vsync(f_vs), .active(f_act), .x(f_x), .y(f_y),
    .line_start(f_ls), .frame_start(f_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .H_POL(0), .V_POL(0), .CNT_W(5)
  ) dut_small (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
    .hsync(s_hs), .vsync(s_vs), .active(s_act), .x(s_x), .y(s_y),
    .line_start(s_ls), .frame_start(s_fs)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // The presented pixel is simply the (n-1)th pixel of the raster since reset.
  function automatic px_t model(input longint n, input bit lce,
                                input int ha, input int hf, input int hsw, input int hb,
                                input int va, input int vf, input int vsw, input int vb);
    px_t e;
    longint idx;
    int ht, vt, ex, ey;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    if (n == 0) begin
      e = '{x: 32'd0, y: 32'd0, act: 1'b0, hs: 1'b1, vs: 1'b1, ls: 1'b0, fs: 1'b0};
    end else begin
      idx = n - 1;
      ex = int'(idx % ht);
      ey = int'((idx / ht) % vt);
      e.x = ex;
      e.y = ey;
      e.act = (ex < ha) && (ey < va);
      e.hs = !((ex >= ha + hf) && (ex < ha + hf + hsw));
      e.vs = !((ey >= va + vf) && (ey < va + vf + vsw));
      e.ls = lce && (ex == 0);
      e.fs = lce && (ex == 0) && (ey == 0);
    end
    return e;
  endfunction

  // Model state: count of pix_ce edges since reset and whether the last edge had one
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_ce <= 0;
      last_ce <= 1'b0;
    end else begin
      last_ce <= pix_ce;
      if (pix_ce) n_ce <= n_ce + 1;
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    px_t ef, es;
    if (chk_en) begin
      ef = model(n_ce, last_ce, 640, 16, 96, 48, 480, 10, 2, 33);
      es = model(n_ce, last_ce, 16, 4, 6, 4, 12, 2, 2, 3);
      chk("full_x", {22'd0, f_x}, ef.x);
      chk("full_y", {22'd0, f_y}, ef.y);
      chk("full_active", {31'd0, f_act}, {31'd0, ef.act});
      chk("full_hsync", {31'd0, f_hs}, {31'd0, ef.hs});
      chk("full_vsync", {31'd0, f_vs}, {31'd0, ef.vs});
      chk("full_line_start", {31'd0, f_ls}, {31'd0, ef.ls});
      chk("full_frame_start", {31'd0, f_fs}, {31'd0, ef.fs});
      chk("small_x", {27'd0, s_x}, es.x);
      chk("small_y", {27'd0, s_y}, es.y);
      chk("small_active", {31'd0, s_act}, {31'd0, es.act});
      chk("small_hsync", {31'd0, s_hs}, {31'd0, es.hs});
      chk("small_vsync", {31'd0, s_vs}, {31'd0, es.vs});
      chk("small_line_start", {31'd0, s_ls}, {31'd0, es.ls});
      chk("small_frame_start", {31'd0, s_fs}, {31'd0, es.fs});
    end
  end

  int last_sfs, last_fls, last_sls, sfs_cnt, fls_cnt;
  int rise_c, ls_high, width;

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    pix_ce = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    pix_ce = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    pix_ce = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_x", {22'd0, f_x}, 32'd0);
    chk("rst_active", {31'd0, f_act}, 32'd0);
    chk("rst_hsync", {31'd0, f_hs}, 32'd1);
    chk("rst_vsync", {31'd0, f_vs}, 32'd1);
    chk("rst_frame_start", {31'd0, f_fs}, 32'd0);

    // Continuous pix_ce from reset
    @(posedge clk);
    #1 rst_n = 1'b1;
    pix_ce = 1'b1;
    last_sfs = 0; last_fls = 0; last_sls = 0; sfs_cnt = 0; fls_cnt = 0;
    for (int k = 1; k <= 1300; k++) begin
      @(posedge clk);
      @(negedge clk);
      case (k)
        1: begin
          chk("first_x", {22'd0, f_x}, 32'd0);
          chk("first_active", {31'd0, f_act}, 32'd1);
          chk("first_frame_start", {31'd0, f_fs}, 32'd1);
          chk("first_line_start", {31'd0, f_ls}, 32'd1);
          chk("first_hsync", {31'd0, f_hs}, 32'd1);
          chk("first_vsync", {31'd0, f_vs}, 32'd1);
        end
        640: chk("x639_active", {31'd0, f_act}, 32'd1);
        641: chk("x640_active", {31'd0, f_act}, 32'd0);
        656: chk("x655_hsync", {31'd0, f_hs}, 32'd1);
        657: chk("x656_hsync", {31'd0, f_hs}, 32'd0);
        752: chk("x751_hsync", {31'd0, f_hs}, 32'd0);
        753: chk("x752_hsync", {31'd0, f_hs}, 32'd1);
        800: chk("x799", {22'd0, f_x}, 32'd799);
        801: begin
          chk("wrap_x", {22'd0, f_x}, 32'd0);
          chk("wrap_y", {22'd0, f_y}, 32'd1);
          chk("wrap_line_start", {31'd0, f_ls}, 32'd1);
          chk("wrap_frame_start", {31'd0, f_fs}, 32'd0);
        end
        346: chk("s_y11_active", {31'd0, s_act}, 32'd1);
        361: chk("s_y12_active", {31'd0, s_act}, 32'd0);
        391: chk("s_y13_vsync", {31'd0, s_vs}, 32'd1);
        421: chk("s_y14_vsync", {31'd0, s_vs}, 32'd0);
        480: chk("s_y15_vsync", {31'd0, s_vs}, 32'd0);
        481: chk("s_y16_vsync", {31'd0, s_vs}, 32'd1);
        570: begin
          chk("s_last_x", {27'd0, s_x}, 32'd29);
          chk("s_last_y", {27'd0, s_y}, 32'd18);
        end
        571: begin
          chk("s_fwrap_y", {27'd0, s_y}, 32'd0);
          chk("s_fwrap_fs", {31'd0, s_fs}, 32'd1);
        end
        default: ;
      endcase
      if (s_fs) begin
        if (last_sfs > 0) chk("s_frame_period", k - last_sfs, 32'd570);
        last_sfs = k;
        sfs_cnt++;
      end
      if (f_ls) begin
        if (last_fls > 0) chk("line_period", k - last_fls, 32'd800);
        last_fls = k;
        fls_cnt++;
      end
      if (s_ls) begin
        if (last_sls > 0) chk("s_line_period", k - last_sls, 32'd30);
        last_sls = k;
      end
    end
    chk("s_frame_count", sfs_cnt, 32'd3);
    chk("line_count", fls_cnt, 32'd2);

    // pix_ce every 4th clk
    do_reset();
    rise_c = -1; ls_high = 0; width = 0;
    for (int c = 0; c < 3300; c++) begin
      @(posedge clk);
      #1 pix_ce = ((c + 1) % 4 == 0);
      @(negedge clk);
      if (f_ls) begin
        ls_high++;
        width++;
        if (width == 1) begin
          if (rise_c >= 0) chk("ce4_line_period", c - rise_c, 32'd3200);
          rise_c = c;
        end
      end else begin
        if (width != 0) chk("ce4_ls_width", width, 32'd1);
        width = 0;
      end
      case (c)
        1: chk("ce4_ls_drop", {31'd0, f_ls}, 32'd0);
        5: chk("ce4_hold_x_a", {22'd0, f_x}, 32'd1);
        7: chk("ce4_hold_x_b", {22'd0, f_x}, 32'd1);
        8: chk("ce4_next_x", {22'd0, f_x}, 32'd2);
        default: ;
      endcase
    end
    chk("ce4_ls_clks", ls_high, 32'd2);

    // Freeze at x=300 for 50 clks
    do_reset();
    repeat (301) @(posedge clk);
    #1 pix_ce = 1'b0;
    repeat (50) begin
      @(negedge clk);
      chk("freeze_x", {22'd0, f_x}, 32'd300);
    end
    #1 pix_ce = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("resume_x", {22'd0, f_x}, 32'd301);

    // Reset mid-frame, full instance inside hsync
    do_reset();
    repeat (701) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_x", {22'd0, f_x}, 32'd700);
    chk("pre_rst_hsync", {31'd0, f_hs}, 32'd0);
    chk("pre_rst_s_x", {27'd0, s_x}, 32'd10);
    chk("pre_rst_s_y", {27'd0, s_y}, 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_x", {22'd0, f_x}, 32'd0);
    chk("midrst_y", {22'd0, f_y}, 32'd0);
    chk("midrst_active", {31'd0, f_act}, 32'd0);
    chk("midrst_hsync", {31'd0, f_hs}, 32'd1);
    chk("midrst_vsync", {31'd0, f_vs}, 32'd1);
    chk("midrst_s_y", {27'd0, s_y}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_fs", {31'd0, f_fs}, 32'd1);
    chk("post_rst_s_fs", {31'd0, s_fs}, 32'd1);
    chk("post_rst_x", {22'd0, f_x}, 32'd0);
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
